// File: rtl/tron_mem_pkg.sv
// Shared types and constants for the CPU memory-port responder.
package tron_mem_pkg;

  // Responder FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int unsigned WORD_BYTES = 2;
  localparam int unsigned BYTE_OFS   = $clog2(WORD_BYTES);
  localparam int unsigned WAIT_CNT_W = 4;

  // Error code bits; any non-zero code fails the access
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

endpackage

// File: rtl/bram_sp.sv
// Single-port RAM: synchronous write, registered read, output holds on writes.
module bram_sp #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_BITS = 10,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] addr,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0] ram [DEPTH];

  // Write commits or read data registers on an enabled edge
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        ram[addr] <= din;
      end else begin
        dout <= ram[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: req/ready handshake, wait states, error decode, RAM.
module mem_responder
  import tron_mem_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH_BITS  = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_req,
  input  logic             mem_we,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] mem_rdata,
  output logic             mem_ready,
  output logic             mem_err
);

  // Counter reload gives exactly WAIT_STATES cycles in ST_WAIT
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  state_t                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    cap_we_q;
  logic [WIDTH-1:0]        cap_addr_q, cap_wdata_q;
  logic                    accept;
  logic [1:0]              err_code;
  logic                    bad;
  logic                    ram_en, ram_we;
  logic [WIDTH-1:0]        ram_dout;
  logic                    ready_d, err_d;
  logic                    read_ok_q, read_ok_d;
  logic [WIDTH-1:0]        hold_q, hold_d;

  // Misaligned byte offset or any address bit above the RAM window
  assign err_code = ((cap_addr_q[BYTE_OFS-1:0] != '0) ? ERR_MISALIGN : ERR_NONE)
                  | (((cap_addr_q >> (DEPTH_BITS + BYTE_OFS)) != '0) ? ERR_RANGE : ERR_NONE);
  assign bad = (err_code != ERR_NONE);

  bram_sp #(
    .WIDTH      (WIDTH),
    .DEPTH_BITS (DEPTH_BITS),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (cap_addr_q[BYTE_OFS +: DEPTH_BITS]),
    .din  (cap_wdata_q),
    .dout (ram_dout)
  );

  // Live RAM output only in the response cycle of a good read
  assign mem_rdata = read_ok_q ? ram_dout : hold_q;

  // Next-state, RAM strobes and response values
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    accept     = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    read_ok_d  = 1'b0;
    hold_d     = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = ST_ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        state_d   = ST_RESP;
        ram_en    = ~bad;
        ram_we    = cap_we_q & ~bad;
        ready_d   = 1'b1;
        err_d     = bad;
        read_ok_d = ~cap_we_q & ~bad;
        if (bad) begin
          hold_d = '0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (read_ok_q) begin
          hold_d = ram_dout;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, wait counter and registered response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      mem_ready  <= 1'b0;
      mem_err    <= 1'b0;
      read_ok_q  <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_ready  <= ready_d;
      mem_err    <= err_d;
      read_ok_q  <= read_ok_d;
      hold_q     <= hold_d;
    end
  end

  // Request capture on the accepting edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else if (accept) begin
      cap_we_q    <= mem_we;
      cap_addr_q  <= mem_addr;
      cap_wdata_q <= mem_wdata;
    end
  end

endmodule
